// File: rtl/cd_global_req_arb_8to4.sv
// Global request crossbar stage: 8 inputs onto 4 LLC ports. Each LLC has its own
// round-robin arbiter and one registered output slot. Requests with no destination are dropped and counted.
module cd_global_req_arb_8to4 #(
   parameter int DATA_W = 64,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            in_vld,
   input  logic [8*DATA_W-1:0]   in_data,
   input  logic [7:0]            dst_o0,
   input  logic [7:0]            dst_o1,
   input  logic [7:0]            dst_o2,
   input  logic [7:0]            dst_o3,
   output logic [7:0]            in_pop,
   output logic [3:0]            out_vld,
   output logic [4*DATA_W-1:0]   out_data,
   input  logic [3:0]            out_rdy,
   output logic [CNT_W-1:0]      drop_cnt
);

   localparam logic [CNT_W+3:0] CntMax = {4'b0000, {CNT_W{1'b1}}};

   logic [3:0][7:0]        req;
   logic [7:0]             noMatch;
   logic [3:0]             dstVec;
   logic [3:0]             slotFree;
   logic [3:0]             grantVld;
   logic [3:0][2:0]        winner;
   logic [2:0]             idx;
   logic [7:0]             grantMask;
   logic [3:0]             dropNum;
   logic [CNT_W+3:0]       dropSum;
   logic [3:0][DATA_W-1:0] selData;

   logic [3:0][2:0]        rrPtr_q, rrPtr_d;
   logic [3:0]             outVld_q, outVld_d;
   logic [3:0][DATA_W-1:0] outData_q, outData_d;
   logic [CNT_W-1:0]       dropCnt_q, dropCnt_d;

   // Each input goes only to the lowest-numbered LLC flagged in its masks.
   always_comb begin
      req     = '0;
      noMatch = '0;
      dstVec  = '0;
      for (int i = 0; i < 8; i++) begin
         dstVec = {dst_o3[i], dst_o2[i], dst_o1[i], dst_o0[i]};
         noMatch[i] = in_vld[i] & ~(|dstVec);
         if (dstVec[0])      req[0][i] = in_vld[i];
         else if (dstVec[1]) req[1][i] = in_vld[i];
         else if (dstVec[2]) req[2][i] = in_vld[i];
         else if (dstVec[3]) req[3][i] = in_vld[i];
      end
   end

   always_comb begin
      grantVld  = '0;
      winner    = '0;
      idx       = '0;
      grantMask = '0;
      selData   = '0;
      slotFree  = ~outVld_q | out_rdy;
      for (int k = 0; k < 4; k++) begin
         if (slotFree[k]) begin
            for (int off = 0; off < 8; off++) begin
               idx = rrPtr_q[k] + 3'(off);
               if (!grantVld[k] && req[k][idx]) begin
                  grantVld[k] = 1'b1;
                  winner[k]   = idx;
               end
            end
         end
         if (grantVld[k]) grantMask[winner[k]] = 1'b1;
         selData[k] = in_data[winner[k]*DATA_W +: DATA_W];
      end
   end

   assign in_pop = reset ? 8'h00 : (grantMask | noMatch);

   always_comb begin
      rrPtr_d   = rrPtr_q;
      outVld_d  = outVld_q & ~out_rdy;
      outData_d = outData_q;
      for (int k = 0; k < 4; k++) begin
         if (grantVld[k]) begin
            outVld_d[k]  = 1'b1;
            outData_d[k] = selData[k];
            rrPtr_d[k]   = winner[k] + 3'd1;
         end
      end
   end

   // Several inputs may drop in the same cycle; the sum clamps rather than wraps.
   always_comb begin
      dropNum = '0;
      for (int i = 0; i < 8; i++) dropNum = dropNum + {3'b000, noMatch[i]};
      dropSum   = {4'b0000, dropCnt_q} + {{CNT_W{1'b0}}, dropNum};
      dropCnt_d = (dropSum > CntMax) ? {CNT_W{1'b1}} : dropSum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rrPtr_q   <= '0;
         outVld_q  <= '0;
         outData_q <= '0;
         dropCnt_q <= '0;
      end else begin
         rrPtr_q   <= rrPtr_d;
         outVld_q  <= outVld_d;
         outData_q <= outData_d;
         dropCnt_q <= dropCnt_d;
      end
   end

   assign out_vld  = outVld_q;
   assign out_data = outData_q;
   assign drop_cnt = dropCnt_q;

endmodule

// File: tb/tb_cd_global_req_arb_8to4.sv
// Directed bench for cd_global_req_arb_8to4; a second instance with a 2-bit
// drop counter shares the stimulus to exercise saturation.
module tb_cd_global_req_arb_8to4;

   localparam int DW = 64;

   logic            clk;
   logic            reset;
   logic [7:0]      inVld;
   logic [8*DW-1:0] inData;
   logic [7:0]      dst0, dst1, dst2, dst3;
   logic [3:0]      outRdy;
   logic [7:0]      inPop, inPop2;
   logic [3:0]      outVld, outVld2;
   logic [4*DW-1:0] outData, outData2;
   logic [15:0]     dropCnt;
   logic [1:0]      dropCnt2;

   int total = 0;
   int bad   = 0;

   cd_global_req_arb_8to4 #(.DATA_W(DW), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .in_vld(inVld), .in_data(inData),
      .dst_o0(dst0), .dst_o1(dst1), .dst_o2(dst2), .dst_o3(dst3),
      .in_pop(inPop), .out_vld(outVld), .out_data(outData),
      .out_rdy(outRdy), .drop_cnt(dropCnt)
   );

   cd_global_req_arb_8to4 #(.DATA_W(DW), .CNT_W(2)) dutSat (
      .clk(clk), .reset(reset), .in_vld(inVld), .in_data(inData),
      .dst_o0(dst0), .dst_o1(dst1), .dst_o2(dst2), .dst_o3(dst3),
      .in_pop(inPop2), .out_vld(outVld2), .out_data(outData2),
      .out_rdy(outRdy), .drop_cnt(dropCnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] flit(input int i);
      return 64'hD00D_0000_0000_0000 + 64'(i * 17 + 5);
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] v, input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3, input logic [3:0] r);
      inVld = v; dst0 = d0; dst1 = d1; dst2 = d2; dst3 = d3; outRdy = r;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] rrExp [6] = '{8'h01, 8'h08, 8'h20, 8'h01, 8'h08, 8'h20};
   int         rrIdx [6] = '{0, 3, 5, 0, 3, 5};

   initial begin
      for (int i = 0; i < 8; i++) inData[i*DW +: DW] = flit(i);
      reset = 1'b1;
      applyStimulus(8'hFF, 8'h0F, 8'h00, 8'h00, 8'h00, 4'hF);
      checkOutput("pop_in_reset", inPop, 8'h00);
      step(); step();
      checkOutput("rst_out_vld", outVld, 4'h0);
      checkOutput("rst_out_data0", outData[0 +: DW], 64'h0);
      checkOutput("rst_drop_cnt", dropCnt, 16'h0);
      reset = 1'b0;

      // Single request into LLC2
      applyStimulus(8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 4'hF);
      checkOutput("single_pop", inPop, 8'h01);
      step();
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);
      checkOutput("single_vld", outVld, 4'h4);
      checkOutput("single_data", outData[2*DW +: DW], flit(0));
      step();
      checkOutput("single_drain", outVld, 4'h0);
      applyStimulus(8'h03, 8'h00, 8'h00, 8'h03, 8'h00, 4'hF);
      checkOutput("single_rr_ptr", inPop, 8'h02);
      step();
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);
      step();

      // Round robin among inputs 0, 3, 5 on LLC0
      for (int n = 0; n < 6; n++) begin
         applyStimulus(8'h29, 8'h29, 8'h00, 8'h00, 8'h00, 4'hF);
         checkOutput($sformatf("rr_pop%0d", n), inPop, rrExp[n]);
         step();
         checkOutput($sformatf("rr_vld%0d", n), outVld, 4'h1);
         checkOutput($sformatf("rr_data%0d", n), outData[0 +: DW], flit(rrIdx[n]));
      end
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);
      step();

      // Back-pressure on LLC1 with inputs 1 and 2 pending
      applyStimulus(8'h06, 8'h00, 8'h06, 8'h00, 8'h00, 4'hD);
      checkOutput("bp_first_pop", inPop, 8'h02);
      step();
      for (int n = 0; n < 5; n++) begin
         applyStimulus(8'h06, 8'h00, 8'h06, 8'h00, 8'h00, 4'hD);
         checkOutput($sformatf("bp_pop%0d", n), inPop, 8'h00);
         checkOutput($sformatf("bp_vld%0d", n), outVld, 4'h2);
         checkOutput($sformatf("bp_data%0d", n), outData[DW +: DW], flit(1));
         step();
      end
      applyStimulus(8'h06, 8'h00, 8'h06, 8'h00, 8'h00, 4'hF);
      checkOutput("bp_release_pop", inPop, 8'h04);
      step();
      checkOutput("bp_release_data", outData[DW +: DW], flit(2));
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);
      step();

      // Parallel grants, then a duplicate-mask input resolved to the lowest LLC
      applyStimulus(8'h0F, 8'h01, 8'h02, 8'h04, 8'h08, 4'hF);
      checkOutput("par_pop", inPop, 8'h0F);
      step();
      checkOutput("par_vld", outVld, 4'hF);
      for (int k = 0; k < 4; k++)
         checkOutput($sformatf("par_data%0d", k), outData[k*DW +: DW], flit(k));
      applyStimulus(8'h10, 8'h00, 8'h10, 8'h00, 8'h10, 4'hF);
      checkOutput("dup_pop", inPop, 8'h10);
      step();
      checkOutput("dup_vld", outVld, 4'h2);
      checkOutput("dup_data", outData[DW +: DW], flit(4));

      // No-match drops and saturation
      for (int n = 0; n < 3; n++) begin
         applyStimulus(8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);
         checkOutput($sformatf("drop_pop%0d", n), inPop, 8'h40);
         step();
      end
      checkOutput("drop_cnt3", dropCnt, 16'd3);
      checkOutput("drop_sat_cnt3", dropCnt2, 2'd3);
      applyStimulus(8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);
      checkOutput("drop_pair_pop", inPop, 8'hC0);
      step();
      checkOutput("drop_cnt5", dropCnt, 16'd5);
      checkOutput("drop_sat_cnt5", dropCnt2, 2'd3);
      applyStimulus(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4'hF);
      step();

      // Reset with all slots full; LLC0 pointer was left at 1 before reset
      applyStimulus(8'h0F, 8'h01, 8'h02, 8'h04, 8'h08, 4'h0);
      step();
      checkOutput("pre_rst_vld", outVld, 4'hF);
      reset = 1'b1;
      applyStimulus(8'h0F, 8'h01, 8'h02, 8'h04, 8'h08, 4'h0);
      checkOutput("mid_rst_pop", inPop, 8'h00);
      step();
      checkOutput("mid_rst_vld", outVld, 4'h0);
      checkOutput("mid_rst_drop", dropCnt, 16'h0);
      checkOutput("mid_rst_data3", outData[3*DW +: DW], 64'h0);
      reset = 1'b0;
      applyStimulus(8'h03, 8'h03, 8'h00, 8'h00, 8'h00, 4'hF);
      checkOutput("post_rst_rr", inPop, 8'h01);
      step();
      checkOutput("post_rst_data", outData[0 +: DW], flit(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
